des_cbc_ctrl: RTL and testbench

DES_CBC_CTRL -- requirements
Module: des_cbc_ctrl

---
 rtl/des_pkg.sv | 106 ++++++++++
 rtl/des_core.sv | 24 ++
 rtl/des_cbc_ctrl.sv | 135 +++++++++++++
 tb/tb_des_cbc_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared types, constants and the DES block function used by the
// CBC controller.
//   block_t      64-bit data/key word
//   cbc_state_t  controller state encoding
//   des_en/des_de  single-block DES encrypt/decrypt (pure combinational)
package des_pkg;

    typedef logic [63:0] block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } cbc_state_t;

    localparam logic CFG_KEY  = 1'b0;
    localparam logic CFG_IV   = 1'b1;
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Permutation tables use DES numbering: bit 1 is the MSB of the source.
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48]  = '{32,1,2,3,4,5,     4,5,6,7,8,9,     8,9,10,11,12,13,
                                 12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                                 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                 2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29,  21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5,  3,28,15,6,21,10,  23,19,12,4,26,8,
                                  16,7,27,20,13,2,  41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};

    // Bit i set: key-schedule round i rotates by two instead of one.
    localparam logic [15:0] DOUBLE_SHIFT = 16'h7EFC;

    // S-boxes S1..S8 at index 7..0; entry (row*16+col) is nibble 0 at the MSB.
    localparam logic [7:0][255:0] SBOX = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic block_t des_crypt(input block_t din, input block_t key, input logic dec);
        logic [55:0]        cd;
        logic [27:0]        c, d;
        logic [15:0][47:0]  ks;
        logic [47:0]        ex, kk;
        logic [63:0]        ip, pre, res;
        logic [31:0]        l, r, t, f;
        logic [5:0]         s6, idx;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
            if (DOUBLE_SHIFT[rnd]) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) ks[rnd][47-j] = cd[56-PC2_T[j]];
        end
        for (int i = 0; i < 64; i++) ip[63-i] = din[64-IP_T[i]];
        l = ip[63:32];
        r = ip[31:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            kk = dec ? ks[15-rnd] : ks[rnd];
            for (int j = 0; j < 48; j++) ex[47-j] = r[32-E_T[j]];
            ex = ex ^ kk;
            for (int b = 0; b < 8; b++) begin
                s6  = ex[47-6*b -: 6];
                idx = {s6[5], s6[0], s6[4:1]};
                t[31-4*b -: 4] = SBOX[7-b][255-4*int'(idx) -: 4];
            end
            for (int j = 0; j < 32; j++) f[31-j] = t[32-P_T[j]];
            {l, r} = {r, l ^ f};
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
        return res;
    endfunction

    function automatic block_t des_en(input block_t din, input block_t key);
        return des_crypt(din, key, 1'b0);
    endfunction

    function automatic block_t des_de(input block_t din, input block_t key);
        return des_crypt(din, key, 1'b1);
    endfunction

endpackage

// File: rtl/des_core.sv
// des_core: combinational DES engine, one block per evaluation.
//   data   block to transform
//   key    64-bit DES key (parity bits ignored)
//   mode   MODE_ENC / MODE_DEC
//   result transformed block
// The path is deliberately deep; the controller holds its inputs stable for
// CORE_LAT cycles, so it is constrained as a multicycle path.
module des_core
    import des_pkg::*;
(
    input  block_t data,
    input  block_t key,
    input  logic   mode,
    output block_t result
);

    block_t enc_out;
    block_t dec_out;

    assign enc_out = des_en(data, key);
    assign dec_out = des_de(data, key);
    assign result  = (mode == MODE_DEC) ? dec_out : enc_out;

endmodule

// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl: CBC chaining controller around a multicycle DES core.
//   cfg_valid/cfg_ready/cfg_kind/cfg_data  key or IV load, IDLE only
//   in_valid/in_ready/in_data/in_mode/in_last  block input
//   out_valid/out_ready/out_data  result, held until accepted
//   blk_cnt  completed blocks (wrapping), busy  state != IDLE
//
// state | meaning
// IDLE  | accepts config (priority) or a new block
// CALC  | core settling, CORE_LAT cycles
// OUT   | result presented, waiting for out_ready
module des_cbc_ctrl
    import des_pkg::*;
#(
    parameter int CORE_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_valid,
    input  logic         cfg_kind,
    input  logic [63:0]  cfg_data,
    output logic         cfg_ready,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         in_mode,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic [15:0]  blk_cnt,
    output logic         busy
);

    cbc_state_t  state_q, state_d;
    block_t      key_reg, iv_reg, chain_reg, blk_reg;
    block_t      core_in, core_out, result, chain_next;
    logic        mode_q, last_q;
    logic [3:0]  lat_cnt;
    logic [15:0] blk_cnt_q;
    logic        cfg_take, blk_take, calc_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        cfg_take  = 1'b0;
        blk_take  = 1'b0;
        calc_done = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                in_ready  = 1'b1;
                if (cfg_valid) begin
                    cfg_take = 1'b1;
                end else if (in_valid) begin
                    blk_take = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (lat_cnt == 4'd0) begin
                    calc_done = 1'b1;
                    state_d   = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign blk_cnt = blk_cnt_q;

    // Chaining: encrypt feeds the ciphertext forward, decrypt feeds the
    // incoming ciphertext forward; mode is per block.
    assign core_in    = (mode_q == MODE_ENC) ? (blk_reg ^ chain_reg) : blk_reg;
    assign result     = (mode_q == MODE_ENC) ? core_out : (core_out ^ chain_reg);
    assign chain_next = (mode_q == MODE_ENC) ? core_out : blk_reg;

    des_core u_core (
        .data   (core_in),
        .key    (key_reg),
        .mode   (mode_q),
        .result (core_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg   <= '0;
            iv_reg    <= '0;
            chain_reg <= '0;
            blk_reg   <= '0;
            mode_q    <= 1'b0;
            last_q    <= 1'b0;
            lat_cnt   <= 4'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
            blk_cnt_q <= 16'd0;
        end else begin
            if (cfg_take) begin
                if (cfg_kind == CFG_IV) begin
                    iv_reg    <= cfg_data;
                    chain_reg <= cfg_data;
                end else begin
                    key_reg <= cfg_data;
                end
            end
            if (blk_take) begin
                blk_reg <= in_data;
                mode_q  <= in_mode;
                last_q  <= in_last;
                lat_cnt <= 4'(CORE_LAT - 1);
            end
            if (state_q == CALC && !calc_done) lat_cnt <= lat_cnt - 4'd1;
            if (calc_done) begin
                out_data  <= result;
                out_valid <= 1'b1;
                // End of chain rewinds to the stored IV for the next message.
                chain_reg <= last_q ? iv_reg : chain_next;
            end
            if (state_q == OUT && out_ready) begin
                out_valid <= 1'b0;
                blk_cnt_q <= blk_cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// tb_des_cbc_ctrl: self-checking bench for des_cbc_ctrl.
// A CORE_LAT=1 instance carries the table vectors and the directed sequences
// through a result scoreboard; a CORE_LAT=4 instance checks latency and
// back-to-back period.
module tb_des_cbc_ctrl;
    import des_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_kind, cfg_ready;
    logic [63:0] cfg_data;
    logic        in_valid, in_ready, in_mode, in_last;
    logic [63:0] in_data;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic [15:0] blk_cnt;
    logic        busy;

    logic        cfg_valid4, cfg_ready4, in_valid4, in_ready4;
    logic        out_valid4, out_ready4, busy4;
    logic [63:0] out_data4;
    logic [15:0] blk_cnt4;

    always #5 clk = ~clk;

    des_cbc_ctrl #(.CORE_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_kind(cfg_kind), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .blk_cnt(blk_cnt), .busy(busy)
    );

    des_cbc_ctrl #(.CORE_LAT(4)) dut4 (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid4), .cfg_kind(cfg_kind), .cfg_data(cfg_data), .cfg_ready(cfg_ready4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data), .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .blk_cnt(blk_cnt4), .busy(busy4)
    );

    typedef struct {
        logic [63:0] key;
        logic [63:0] iv;
        logic        mode;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] exp;
        bit          chk;
    } sb_t;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT_A  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;

    vec_t        tbl [9];
    sb_t         sbq [$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [63:0] last_out = '0;
    logic [15:0] exp_cnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_assert++;
        n_fail++;
        $display("FAIL %s: got timeout, expected completion", name);
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_output: got %h, expected no output", out_data);
            end else begin
                e = sbq.pop_front();
                last_out = out_data;
                if (e.chk) check("sb_out_data", out_data, e.exp);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic kind, input logic [63:0] d);
        cfg_kind  = kind;
        cfg_data  = d;
        cfg_valid = 1'b1;
        sync();
        cfg_valid = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input logic m, input logic l,
                        input logic [63:0] e, input bit chk, input bit push);
        int k = 0;
        while (!in_ready && k < 50) begin
            sync();
            k++;
        end
        if (!in_ready) timeout_fail("send_wait_ready");
        in_data  = d;
        in_mode  = m;
        in_last  = l;
        in_valid = 1'b1;
        sync();
        in_valid = 1'b0;
        if (push) sbq.push_back('{e, chk});
    endtask

    task automatic drain();
        int k = 0;
        while ((sbq.size() != 0 || busy) && k < 100) begin
            sync();
            k++;
        end
        if (k >= 100) timeout_fail("drain");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        logic [63:0] c2;
        int          k;
        int          acc0, acc1;

        tbl[0] = '{KEY_A, 64'h0, MODE_ENC, PT_A, CT_A};
        tbl[1] = '{KEY_A, 64'h0, MODE_DEC, CT_A, PT_A};
        tbl[2] = '{64'h0E329232EA6D0D73, 64'h0, MODE_ENC, 64'h8787878787878787, 64'h0};
        tbl[3] = '{64'h0123456789ABCDEF, 64'h0, MODE_ENC, 64'h4E6F772069732074, 64'h3FA40E8A984D4815};
        tbl[4] = '{64'h0123456789ABCDEF, 64'h0, MODE_DEC, 64'h3FA40E8A984D4815, 64'h4E6F772069732074};
        tbl[5] = '{64'h0101010101010101, 64'h0, MODE_ENC, 64'h0, 64'h8CA64DE9C1B123A7};
        tbl[6] = '{64'h0101010101010101, 64'h0, MODE_DEC, 64'h95F8A5E5DD31D900, 64'h8000000000000000};
        tbl[7] = '{KEY_A, PT_A, MODE_ENC, 64'h0, CT_A};
        tbl[8] = '{KEY_A, PT_A, MODE_DEC, CT_A, 64'h0};

        rst = 1'b1;
        cfg_valid = 0; cfg_kind = 0; cfg_data = '0;
        in_valid = 0; in_mode = 0; in_last = 0; in_data = '0;
        out_ready = 1'b1;
        cfg_valid4 = 0; in_valid4 = 0; out_ready4 = 1'b1;
        repeat (3) sync();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_blk_cnt", blk_cnt, 16'h0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        sync();
        check("post_rst_cfg_ready", cfg_ready, 1'b1);
        check("post_rst_in_ready", in_ready, 1'b1);

        // Table vectors: single-block chains (in_last) so each is ECB after the IV.
        for (int i = 0; i < 9; i++) begin
            cfg(CFG_KEY, tbl[i].key);
            cfg(CFG_IV, tbl[i].iv);
            send(tbl[i].din, tbl[i].mode, 1'b1, tbl[i].exp, 1'b1, 1'b1);
            sync();
            check("latency_out_valid", out_valid, 1'b1);
            drain();
            exp_cnt = exp_cnt + 16'd1;
            check("tbl_blk_cnt", blk_cnt, exp_cnt);
        end

        // Two-block chain out and back.
        cfg(CFG_KEY, KEY_A);
        cfg(CFG_IV, 64'h0);
        send(PT_A, MODE_ENC, 1'b0, CT_A, 1'b1, 1'b1);
        send(PT_A, MODE_ENC, 1'b1, 64'h0, 1'b0, 1'b1);
        drain();
        c2 = last_out;
        check("chain_enc_rewind", dut.chain_reg, 64'h0);
        send(CT_A, MODE_DEC, 1'b0, PT_A, 1'b1, 1'b1);
        send(c2, MODE_DEC, 1'b1, PT_A, 1'b1, 1'b1);
        drain();
        check("chain_dec_rewind", dut.chain_reg, 64'h0);
        exp_cnt = exp_cnt + 16'd4;
        check("chain_blk_cnt", blk_cnt, exp_cnt);

        // Backpressure: result held, no new input, counter frozen.
        out_ready = 1'b0;
        send(PT_A, MODE_ENC, 1'b1, CT_A, 1'b1, 1'b1);
        sync();
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_data", out_data, CT_A);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_blk_cnt", blk_cnt, exp_cnt);
            sync();
        end
        out_ready = 1'b1;
        drain();
        exp_cnt = exp_cnt + 16'd1;
        check("bp_blk_cnt_after", blk_cnt, exp_cnt);

        // Config beats block in the same cycle; the new IV applies to that block.
        cfg_kind = CFG_IV; cfg_data = PT_A; cfg_valid = 1'b1;
        in_data = 64'h0; in_mode = MODE_ENC; in_last = 1'b1; in_valid = 1'b1;
        sync();
        check("prio_block_held", busy, 1'b0);
        check("prio_iv_taken", dut.iv_reg, PT_A);
        cfg_valid = 1'b0;
        sync();
        in_valid = 1'b0;
        sbq.push_back('{CT_A, 1'b1});
        check("prio_block_next", busy, 1'b1);
        drain();

        // Reset while the block is in CALC.
        send(PT_A, MODE_ENC, 1'b1, 64'h0, 1'b0, 1'b0);
        check("mid_in_calc", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_out_valid", out_valid, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_key", dut.key_reg, 64'h0);
        check("mid_iv", dut.iv_reg, 64'h0);
        check("mid_chain", dut.chain_reg, 64'h0);
        check("mid_out_data", out_data, 64'h0);
        check("mid_blk_cnt", blk_cnt, 16'h0);
        check("mid_lat_cnt", dut.lat_cnt, 4'h0);
        sync();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sync();
            check("mid_no_output", out_valid, 1'b0);
        end

        // Counter wrap.
        cfg(CFG_KEY, KEY_A);
        cfg(CFG_IV, 64'h0);
        force dut.blk_cnt_q = 16'hFFFF;
        #1;
        release dut.blk_cnt_q;
        check("wrap_preload", blk_cnt, 16'hFFFF);
        send(PT_A, MODE_ENC, 1'b1, CT_A, 1'b1, 1'b1);
        drain();
        check("wrap_blk_cnt", blk_cnt, 16'h0000);

        // CORE_LAT = 4 instance: latency and back-to-back period.
        cfg_kind = CFG_KEY; cfg_data = KEY_A; cfg_valid4 = 1'b1;
        sync();
        cfg_kind = CFG_IV; cfg_data = 64'h0;
        sync();
        cfg_valid4 = 1'b0;
        in_data = PT_A; in_mode = MODE_ENC; in_last = 1'b1; in_valid4 = 1'b1;
        sync();
        in_valid4 = 1'b0;
        k = 0;
        while (!out_valid4 && k < 20) begin
            sync();
            k++;
        end
        check("lat4_edges", 64'(k), 64'd4);
        check("lat4_out_data", out_data4, CT_A);
        sync();
        check("lat4_blk_cnt", blk_cnt4, 16'd1);
        check("lat4_out_valid_clr", out_valid4, 1'b0);

        in_valid4 = 1'b1;
        acc0 = cyc;
        sync();
        k = 0;
        while (!in_ready4 && k < 30) begin
            sync();
            k++;
        end
        acc1 = cyc;
        sync();
        in_valid4 = 1'b0;
        check("lat4_period", 64'(acc1 - acc0), 64'd6);
        k = 0;
        while (busy4 && k < 30) begin
            sync();
            k++;
        end
        check("lat4_blk_cnt_final", blk_cnt4, 16'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
